// File: rtl/lisp_core_pkg.sv
// Shared definitions for the Lisp evaluator: word layout, type tags,
// error codes, FSM state encoding and the 7-segment hex decoder.
package lisp_defs;

   localparam int WORD_W = 16;
   localparam int TYPE_W = 3;
   localparam int ADDR_W = 12;
   localparam int TYPE_MSB = 14;
   localparam int TYPE_LSB = 12;

   localparam logic [TYPE_W-1:0] TYPE_NIL    = 3'd0;
   localparam logic [TYPE_W-1:0] TYPE_NUMBER = 3'd1;
   localparam logic [TYPE_W-1:0] TYPE_CONS   = 3'd2;

   localparam logic [WORD_W-1:0] LISP_NIL = 16'h0000;

   localparam logic [3:0] ERR_NONE = 4'd0;
   localparam logic [3:0] ERR_TYPE = 4'd1;
   localparam logic [3:0] ERR_ADDR = 4'd2;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_EVAL    = 4'd1,
      S_MEMWAIT = 4'd2,
      S_HALT    = 4'd3,
      S_ERROR   = 4'd4
   } state_t;

   // Hex nibble to active-low cathodes {dp,g,f,e,d,c,b,a}; dp kept off.
   function automatic logic [7:0] hex_cathodes(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'h00;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return {1'b1, ~seg};
   endfunction

endpackage

// File: rtl/lisp_core_memory.sv
// Word memory for the evaluator: synchronous one-cycle read, one write
// port. Contents are never reset so a bench may preload memory[] by
// hierarchical reference.
module lisp_memory
   import lisp_defs::*;
#(
   parameter int MemorySize = 256,
   parameter int AddrWidth  = $clog2(MemorySize)
) (
   input  logic                 clk,
   input  logic                 re,
   input  logic [AddrWidth-1:0] raddr,
   input  logic                 we,
   input  logic [AddrWidth-1:0] waddr,
   input  logic [WORD_W-1:0]    wdata,
   output logic [WORD_W-1:0]    rdata
);

   logic [WORD_W-1:0] memory [MemorySize];

   // Write port: stores one word when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         memory[waddr] <= wdata;
      end
   end

   // Read port: data is valid the cycle after re is asserted.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= memory[raddr];
      end
   end

endmodule

// File: rtl/lisp_core.sv
// Top-level Lisp evaluator: latches a tagged word from the switches on a
// start edge, evaluates it against internal memory, shows the result.
// Optional feature macro LISP_CORE_SEVSEG_EN enables the multiplexed
// 7-segment hex display of val; otherwise the display stays blank.
module lisp_core
   import lisp_defs::*;
#(
   parameter int MemorySize   = 256,
   parameter int REFRESH_BITS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_start,
   input  logic [WORD_W-1:0] switches,
   output logic [7:0]        cathodes,
   output logic [3:0]        anodes,
   output logic [15:0]       leds
);

   localparam int AW = $clog2(MemorySize);

   state_t            state;
   logic [WORD_W-1:0] expr;
   logic [WORD_W-1:0] val;
   logic [3:0]        error;
   logic              btn_prev;
   logic              start_edge;
   logic              addr_ok;
   logic              mem_re;
   logic [WORD_W-1:0] mem_rdata;
   logic [TYPE_W-1:0] expr_type;

   assign start_edge = btn_start & ~btn_prev;
   assign expr_type  = expr[TYPE_MSB:TYPE_LSB];
   assign addr_ok    = ({20'd0, expr[ADDR_W-1:0]} < 32'(MemorySize));
   // The read is issued from Eval so its data lands exactly in MemWait.
   assign mem_re     = (state == S_EVAL);

   lisp_memory #(
      .MemorySize (MemorySize),
      .AddrWidth  (AW)
   ) mem (
      .clk   (clk),
      .re    (mem_re),
      .raddr (expr[AW-1:0]),
      .we    (1'b0),
      .waddr ('0),
      .wdata ('0),
      .rdata (mem_rdata)
   );

   // Evaluator FSM: start-edge detection, expression latch, result/error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         expr     <= '0;
         val      <= '0;
         error    <= ERR_NONE;
         btn_prev <= 1'b0;
      end else begin
         btn_prev <= btn_start;
         case (state)
            S_IDLE: begin
               if (start_edge) begin
                  expr  <= switches;
                  state <= S_EVAL;
               end
            end
            S_EVAL: begin
               case (expr_type)
                  TYPE_NUMBER: begin
                     if (addr_ok) begin
                        state <= S_MEMWAIT;
                     end else begin
                        error <= ERR_ADDR;
                        state <= S_ERROR;
                     end
                  end
                  TYPE_CONS: begin
                     val   <= expr;
                     state <= S_HALT;
                  end
                  TYPE_NIL: begin
                     val   <= LISP_NIL;
                     state <= S_HALT;
                  end
                  default: begin
                     error <= ERR_TYPE;
                     state <= S_ERROR;
                  end
               endcase
            end
            S_MEMWAIT: begin
               val   <= mem_rdata;
               state <= S_HALT;
            end
            S_HALT, S_ERROR: begin
               if (start_edge) begin
                  error <= ERR_NONE;
                  expr  <= switches;
                  state <= S_EVAL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign leds = {state, error, val[7:0]};

`ifdef LISP_CORE_SEVSEG_EN
   logic [REFRESH_BITS-1:0] refresh;
   logic [1:0]              digit_sel;
   logic [3:0]              nibble;

   assign digit_sel = refresh[REFRESH_BITS-1 -: 2];

   // Pick the val nibble belonging to the currently scanned digit.
   always_comb begin
      nibble = val[3:0];
      case (digit_sel)
         2'd0: nibble = val[3:0];
         2'd1: nibble = val[7:4];
         2'd2: nibble = val[11:8];
         default: nibble = val[15:12];
      endcase
   end

   // Refresh scan: registered anode/cathode drive, blank out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh  <= '0;
         anodes   <= 4'hF;
         cathodes <= 8'hFF;
      end else begin
         refresh  <= refresh + 1'b1;
         anodes   <= ~(4'b0001 << digit_sel);
         cathodes <= hex_cathodes(nibble);
      end
   end
`else
   logic sevseg_unused;
   assign sevseg_unused = (REFRESH_BITS > 0);
   assign cathodes      = 8'hFF;
   assign anodes        = 4'hF;
`endif

endmodule

// File: tb/tb_lisp_core.sv
// Directed bench for lisp_core: reset, each expression type, address
// boundary, error codes, busy/hold start handling, abort and display.
`timescale 1ns/1ps
module tb_lisp_core;

   logic        clk;
   logic        rst;
   logic        btn_start;
   logic [15:0] switches;
   logic [7:0]  cathodes;
   logic [3:0]  anodes;
   logic [15:0] leds;

   int pass_cnt  = 0;
   int total_cnt = 0;

   lisp_core #(
      .MemorySize   (256),
      .REFRESH_BITS (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .switches  (switches),
      .cathodes  (cathodes),
      .anodes    (anodes),
      .leds      (leds)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver: one-cycle start pulse; returns at the negedge after the
   // sampling posedge (state should then be Eval).
   task automatic pulse_start(input logic [15:0] sw);
      @(negedge clk);
      switches  = sw;
      btn_start = 1'b1;
      @(negedge clk);
      btn_start = 1'b0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      btn_start = 1'b0;
      switches  = 16'h0000;
      step(3);
      total_cnt++;
      if (leds !== 16'h0000) $display("FAIL reset_leds got=%h exp=0000", leds);
      else pass_cnt++;
      total_cnt++;
      if (dut.val !== 16'h0000) $display("FAIL reset_val got=%h exp=0000", dut.val);
      else pass_cnt++;
      total_cnt++;
      if (dut.state !== 4'd0) $display("FAIL reset_state got=%0d exp=0", dut.state);
      else pass_cnt++;
      total_cnt++;
      if ({cathodes, anodes} !== 12'hFFF) $display("FAIL reset_display got=%h/%h exp=FF/F", cathodes, anodes);
      else pass_cnt++;
      rst = 1'b1;
      step(2);
      total_cnt++;
      if (dut.state !== 4'd0) $display("FAIL idle_no_start got=%0d exp=0", dut.state);
      else pass_cnt++;
   endtask

   task automatic test_number();
      dut.mem.memory[1]   = 16'hDEAD;
      dut.mem.memory[255] = 16'h1234;
      pulse_start(16'h1001);
      total_cnt++;
      if (dut.state !== 4'd1) $display("FAIL num_eval got=%0d exp=1", dut.state);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (dut.state !== 4'd2) $display("FAIL num_memwait got=%0d exp=2", dut.state);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (dut.val !== 16'hDEAD) $display("FAIL num_val got=%h exp=DEAD", dut.val);
      else pass_cnt++;
      total_cnt++;
      if (leds !== 16'h30AD) $display("FAIL num_leds got=%h exp=30AD", leds);
      else pass_cnt++;
      // highest valid address
      pulse_start(16'h10FF);
      step(2);
      total_cnt++;
      if (dut.val !== 16'h1234) $display("FAIL num_top_addr got=%h exp=1234", dut.val);
      else pass_cnt++;
      total_cnt++;
      if (leds !== 16'h3034) $display("FAIL num_top_leds got=%h exp=3034", leds);
      else pass_cnt++;
   endtask

   task automatic test_cons_nil();
      dut.mem.memory[3] = 16'h0001;
      dut.mem.memory[4] = 16'h0002;
      pulse_start(16'h2004);
      step(1);
      total_cnt++;
      if (dut.val !== 16'h2004) $display("FAIL cons_val got=%h exp=2004", dut.val);
      else pass_cnt++;
      total_cnt++;
      if (leds !== 16'h3004) $display("FAIL cons_leds got=%h exp=3004", leds);
      else pass_cnt++;
      pulse_start(16'h0000);
      step(1);
      total_cnt++;
      if (dut.val !== 16'h0000) $display("FAIL nil_val got=%h exp=0000", dut.val);
      else pass_cnt++;
      total_cnt++;
      if (leds !== 16'h3000) $display("FAIL nil_leds got=%h exp=3000", leds);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      pulse_start(16'h7005);
      step(1);
      total_cnt++;
      if (leds !== 16'h4100) $display("FAIL err_type_leds got=%h exp=4100", leds);
      else pass_cnt++;
      pulse_start(16'h1100);
      total_cnt++;
      if (dut.error !== 4'd0) $display("FAIL err_cleared got=%0d exp=0", dut.error);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (leds !== 16'h4200) $display("FAIL err_addr_leds got=%h exp=4200", leds);
      else pass_cnt++;
      total_cnt++;
      if (dut.val !== 16'h0000) $display("FAIL err_val_held got=%h exp=0000", dut.val);
      else pass_cnt++;
   endtask

   task automatic test_busy_and_hold();
      pulse_start(16'h1001);
      // new edge while in Eval, then held high through Halt
      switches  = 16'h2004;
      btn_start = 1'b1;
      step(5);
      total_cnt++;
      if (leds !== 16'h30AD) $display("FAIL hold_no_retrigger got=%h exp=30AD", leds);
      else pass_cnt++;
      total_cnt++;
      if (dut.val !== 16'hDEAD) $display("FAIL busy_ignored got=%h exp=DEAD", dut.val);
      else pass_cnt++;
      btn_start = 1'b0;
      step(1);
   endtask

   task automatic test_abort_restart();
      bit ok;
      pulse_start(16'h1001);
      step(1);
      total_cnt++;
      if (dut.state !== 4'd2) $display("FAIL abort_pre got=%0d exp=2", dut.state);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({dut.state, dut.val} !== 20'h00000) $display("FAIL abort_async got=%0d/%h exp=0/0000", dut.state, dut.val);
      else pass_cnt++;
      step(2);
      rst = 1'b1;
      step(1);
      total_cnt++;
      if (leds !== 16'h0000) $display("FAIL abort_leds got=%h exp=0000", leds);
      else pass_cnt++;
      pulse_start(16'h2004);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (dut.state === 4'd3) ok = 1'b1;
         else step(1);
      end
      total_cnt++;
      if (!ok) $display("FAIL restart_timeout got=%0d exp=3", dut.state);
      else if (dut.val !== 16'h2004) $display("FAIL restart_val got=%h exp=2004", dut.val);
      else pass_cnt++;
      pulse_start(16'h1003);
      step(2);
      total_cnt++;
      if (dut.val !== 16'h0001) $display("FAIL restart_halt_val got=%h exp=0001", dut.val);
      else pass_cnt++;
   endtask

   task automatic test_display();
      pulse_start(16'h1001);
      step(2);
`ifdef LISP_CORE_SEVSEG_EN
      begin
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 64 && !ok; i++) begin
            if (anodes === 4'hE) ok = 1'b1;
            else step(1);
         end
         total_cnt++;
         if (!ok || cathodes !== 8'hA1) $display("FAIL seg_digit0 got=%h/%h exp=E/A1", anodes, cathodes);
         else pass_cnt++;
         ok = 1'b0;
         for (int i = 0; i < 64 && !ok; i++) begin
            if (anodes === 4'hD) ok = 1'b1;
            else step(1);
         end
         total_cnt++;
         if (!ok || cathodes !== 8'h88) $display("FAIL seg_digit1 got=%h/%h exp=D/88", anodes, cathodes);
         else pass_cnt++;
      end
`else
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if ({cathodes, anodes} !== 12'hFFF) $display("FAIL seg_blank got=%h/%h exp=FF/F", cathodes, anodes);
         else pass_cnt++;
         step(3);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_number();
      test_cons_nil();
      test_errors();
      test_busy_and_hold();
      test_abort_restart();
      test_display();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
